// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad path (scanner and ac_four_digit).
// Key codes are {row, col} pairs matching the scanner's key_row/key_col outputs.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        ARM,
        HELD
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_1    = {2'd0, 2'd0};
    localparam key_code_t KEY_2    = {2'd0, 2'd1};
    localparam key_code_t KEY_3    = {2'd0, 2'd2};
    localparam key_code_t KEY_A    = {2'd0, 2'd3};
    localparam key_code_t KEY_4    = {2'd1, 2'd0};
    localparam key_code_t KEY_5    = {2'd1, 2'd1};
    localparam key_code_t KEY_6    = {2'd1, 2'd2};
    localparam key_code_t KEY_B    = {2'd1, 2'd3};
    localparam key_code_t KEY_7    = {2'd2, 2'd0};
    localparam key_code_t KEY_8    = {2'd2, 2'd1};
    localparam key_code_t KEY_9    = {2'd2, 2'd2};
    localparam key_code_t KEY_C    = {2'd2, 2'd3};
    localparam key_code_t KEY_STAR = {2'd3, 2'd0};
    localparam key_code_t KEY_0    = {2'd3, 2'd1};
    localparam key_code_t KEY_HASH = {2'd3, 2'd2};
    localparam key_code_t KEY_D    = {2'd3, 2'd3};

    // Result of classifying one synchronised row sample.
    typedef struct packed {
        logic       valid;
        logic [1:0] row;
    } hit_t;

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        col_drive      = COL_IDLE;
        col_drive[idx] = 1'b0;
    endfunction

    // Exactly one low row is a hit; idle and multi-row (ghosted) samples are not.
    function automatic hit_t classify(input logic [NUM_ROWS-1:0] rows);
        case (rows)
            4'b1110: classify = '{valid: 1'b1, row: 2'd0};
            4'b1101: classify = '{valid: 1'b1, row: 2'd1};
            4'b1011: classify = '{valid: 1'b1, row: 2'd2};
            4'b0111: classify = '{valid: 1'b1, row: 2'd3};
            default: classify = '{valid: 1'b0, row: 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row returns.
// Resets to all ones so an idle (pulled-up) keypad is seen during reset.
module kp_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments so both stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, row debounce, and a one-cycle
// keypad_int strobe per confirmed press with key_row/key_col set up a cycle early.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [1:0] key_row,
    output logic [1:0] key_col,
    output logic       keypad_int
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_FINAL = DEB_W'(DEBOUNCE_CNT - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [1:0]       cand_row, cand_row_nxt;
    logic [3:0]       row_s;
    logic             dwell_end;
    logic             load_key;
    hit_t             hit;

    kp_row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (row_in),
        .dout  (row_s)
    );

    assign dwell_end = (div_cnt == DIV_LAST);
    assign hit       = classify(row_s);
    // The column stays frozen outside SCAN, so col_idx doubles as the candidate column.
    assign col_out   = col_drive(col_idx);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        deb_cnt_nxt  = deb_cnt;
        col_idx_nxt  = col_idx;
        cand_row_nxt = cand_row;
        load_key     = 1'b0;

        case (state)
            SCAN: begin
                if (dwell_end) begin
                    if (hit.valid) begin
                        cand_row_nxt = hit.row;
                        deb_cnt_nxt  = DEB_W'(1);
                        state_nxt    = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (dwell_end) begin
                    if (hit.valid && hit.row == cand_row) begin
                        if (deb_cnt == DEB_FINAL) begin
                            load_key    = 1'b1;
                            deb_cnt_nxt = '0;
                            state_nxt   = ARM;
                        end else begin
                            deb_cnt_nxt = deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_nxt = '0;
                        col_idx_nxt = col_idx + 2'd1;
                        state_nxt   = SCAN;
                    end
                end
            end
            ARM: begin
                state_nxt = HELD;
            end
            HELD: begin
                // Release must be seen on consecutive samples; any hit restarts the count.
                if (dwell_end) begin
                    if (hit.valid) begin
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_FINAL) begin
                        deb_cnt_nxt = '0;
                        col_idx_nxt = col_idx + 2'd1;
                        state_nxt   = SCAN;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_W'(1);
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SCAN;
            div_cnt    <= '0;
            deb_cnt    <= '0;
            col_idx    <= 2'd0;
            cand_row   <= 2'd0;
            key_row    <= 2'd0;
            key_col    <= 2'd0;
            keypad_int <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= dwell_end ? '0 : div_cnt + DIV_W'(1);
            deb_cnt    <= deb_cnt_nxt;
            col_idx    <= col_idx_nxt;
            cand_row   <= cand_row_nxt;
            keypad_int <= (state == ARM);
            if (load_key) begin
                key_row <= cand_row;
                key_col <= col_idx;
            end
        end
    end

endmodule
